// File: rtl/vape_pkg.sv
// Shared definitions for the VAPE EXEC latch slice.
//
// Contents:
//   vape_state_e  - latch FSM states
//   CAUSE_*       - bit positions within the 6-bit violation cause word
//   META_MIN / EXEC_MIN - base word addresses of the META and EXEC windows
//   viol_cause()  - builds a cause word from the per-property verdicts
package vape_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2,
      FAIL = 2'd3
   } vape_state_e;

   localparam int CAUSE_IMM  = 0;
   localparam int CAUSE_ATOM = 1;
   localparam int CAUSE_RST  = 2;
   localparam int CAUSE_OUT  = 3;
   localparam int CAUSE_BND  = 4;
   localparam int CAUSE_CFG  = 5;
   localparam int CAUSE_W    = 6;

   localparam logic [15:0] META_MIN = 16'hFF00;
   localparam logic [15:0] EXEC_MIN = 16'hFF08;

   // The monitor's verdicts are 1 = ok, so a failing property is a 0 that
   // becomes a set bit in the cause word. verd is {exec5..exec1}.
   function automatic logic [CAUSE_W-1:0] viol_cause(input logic       cfg,
                                                      input logic [4:0] verd);
      logic [CAUSE_W-1:0] c;
      c                   = '0;
      c[CAUSE_BND:CAUSE_IMM] = ~verd;
      c[CAUSE_CFG]        = cfg;
      return c;
   endfunction

endpackage

// File: rtl/vape_exec_regs.sv
// Registered read port for the EXEC window.
//
// A read request (rd_en) at one of four word addresses loads rd_data on the
// next clock and raises rd_valid for exactly that cycle. Other addresses, and
// cycles with no request, leave rd_data unchanged and rd_valid low. The word
// values are sampled in the request cycle, so the reader sees the state from
// before that edge's update.
//
// Ports:
//   clk, reset_n   - clock, synchronous active-low reset
//   rd_en          - read strobe (data_en & ~data_wr)
//   addr           - word address of the request
//   flag_i         - sticky EXEC flag
//   cause_i        - 6-bit cause of the first violation
//   viol_pc_i      - PC of the first violation
//   cyc_i          - cycle-offset word (already gated by the caller)
//   rd_data_o      - registered read data
//   rd_valid_o     - one-cycle qualifier for rd_data_o
module vape_exec_regs
   import vape_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = EXEC_MIN
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               rd_en,
   input  logic [15:0]        addr,
   input  logic               flag_i,
   input  logic [CAUSE_W-1:0] cause_i,
   input  logic [15:0]        viol_pc_i,
   input  logic [15:0]        cyc_i,
   output logic [15:0]        rd_data_o,
   output logic               rd_valid_o
);

   localparam logic [15:0] ADDR_FLAG  = BASE_ADDR;
   localparam logic [15:0] ADDR_CAUSE = BASE_ADDR + 16'd2;
   localparam logic [15:0] ADDR_PC    = BASE_ADDR + 16'd4;
   localparam logic [15:0] ADDR_CYC   = BASE_ADDR + 16'd6;

   logic [15:0] rd_data_q, rd_data_d;
   logic        rd_valid_q, rd_valid_d;

   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      if (rd_en) begin
         rd_valid_d = 1'b1;
         unique case (addr)
            ADDR_FLAG:  rd_data_d = {15'b0, flag_i};
            ADDR_CAUSE: rd_data_d = {{(16-CAUSE_W){1'b0}}, cause_i};
            ADDR_PC:    rd_data_d = viol_pc_i;
            ADDR_CYC:   rd_data_d = cyc_i;
            default:    rd_valid_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/vape_exec_latch.sv
// Sticky EXEC flag and first-violation recorder behind the VAPE monitor.
//
// Turns the monitor's per-cycle exec verdict into the EXEC flag reported by
// attestation, captures cause/PC/cycle offset of the first violation of a
// run, counts violating cycles, and exposes the records as read-only words.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no run seen since reset; flag 0
//   RUN   | inside ER after a clean entry; flag 1, cyc counting
//   DONE  | reached ER_max cleanly; flag 1 until any violation
//   FAIL  | violation captured; flag 0 until a fresh clean entry
//
// Ports:
//   clk, reset_n            - clock, synchronous active-low reset
//   pc, ER_min, ER_max      - program counter and executable region bounds
//   exec, exec1..exec5      - aggregate and per-property monitor verdicts
//   data_en/data_wr/addr    - CPU data access (reads of the EXEC window)
//   exec_flag               - sticky EXEC flag
//   rd_data, rd_valid       - registered read port
module vape_exec_latch
   import vape_pkg::*;
#(
   parameter logic [15:0] EXEC_ADDR = EXEC_MIN,
   parameter int          CNT_W     = 16,
   parameter int          VCNT_W    = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] pc,
   input  logic [15:0] ER_min,
   input  logic [15:0] ER_max,
   input  logic        exec,
   input  logic        exec1,
   input  logic        exec2,
   input  logic        exec3,
   input  logic        exec4,
   input  logic        exec5,
   input  logic        data_en,
   input  logic        data_wr,
   input  logic [15:0] data_addr,
   output logic        exec_flag,
   output logic [15:0] rd_data,
   output logic        rd_valid
);

   vape_state_e        state_q, state_d;
   logic [CAUSE_W-1:0] cause_q, cause_d;
   logic [15:0]        viol_pc_q, viol_pc_d;
   logic [CNT_W-1:0]   cyc_q, cyc_d;
   logic [VCNT_W-1:0]  vcnt_q, vcnt_d;
   logic [15:0]        er_min_q, er_min_d;
   logic [15:0]        er_max_q, er_max_d;

   logic               entry;
   logic               go_fail;
   logic               cfg_viol;
   logic               do_entry;
   logic [15:0]        cyc_word;

   assign entry = (pc == ER_min);

   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      viol_pc_d = viol_pc_q;
      cyc_d     = cyc_q;
      vcnt_d    = vcnt_q;
      er_min_d  = er_min_q;
      er_max_d  = er_max_q;
      go_fail   = 1'b0;
      cfg_viol  = 1'b0;
      do_entry  = 1'b0;

      if (!exec && (vcnt_q != {VCNT_W{1'b1}}))
         vcnt_d = vcnt_q + VCNT_W'(1);

      unique case (state_q)
         IDLE: begin
            // A violating cycle outside ER only counts; at ER_min it is a
            // failed entry and gets captured.
            if (entry) begin
               if (!exec) go_fail  = 1'b1;
               else       do_entry = 1'b1;
            end
         end
         RUN: begin
            if (!exec) begin
               go_fail = 1'b1;
            end else if ((ER_min != er_min_q) || (ER_max != er_max_q)) begin
               go_fail  = 1'b1;
               cfg_viol = 1'b1;
            end else if (pc == er_max_q) begin
               state_d = DONE;
            end else if (cyc_q != {CNT_W{1'b1}}) begin
               cyc_d = cyc_q + CNT_W'(1);
            end
         end
         DONE: begin
            // Violations after exit still drop the flag (e.g. output tampering).
            if (!exec)      go_fail  = 1'b1;
            else if (entry) do_entry = 1'b1;
         end
         FAIL: begin
            if (entry && exec) do_entry = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (go_fail) begin
         state_d   = FAIL;
         cause_d   = viol_cause(cfg_viol, {exec5, exec4, exec3, exec2, exec1});
         viol_pc_d = pc;
      end

      if (do_entry) begin
         state_d   = (ER_min == ER_max) ? DONE : RUN;
         cause_d   = '0;
         viol_pc_d = '0;
         cyc_d     = '0;
         er_min_d  = ER_min;
         er_max_d  = ER_max;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cause_q   <= '0;
         viol_pc_q <= '0;
         cyc_q     <= '0;
         vcnt_q    <= '0;
         er_min_q  <= '0;
         er_max_q  <= '0;
      end else begin
         state_q   <= state_d;
         cause_q   <= cause_d;
         viol_pc_q <= viol_pc_d;
         cyc_q     <= cyc_d;
         vcnt_q    <= vcnt_d;
         er_min_q  <= er_min_d;
         er_max_q  <= er_max_d;
      end
   end

   assign exec_flag = (state_q == RUN) || (state_q == DONE);

   // The offset is only meaningful once a run has ended one way or another.
   always_comb begin
      cyc_word = '0;
      if ((state_q == FAIL) || (state_q == DONE)) begin
         for (int i = 0; i < 16; i++)
            if (i < CNT_W) cyc_word[i] = cyc_q[i];
      end
   end

   vape_exec_regs #(
      .BASE_ADDR (EXEC_ADDR)
   ) u_regs (
      .clk        (clk),
      .reset_n    (reset_n),
      .rd_en      (data_en && !data_wr),
      .addr       (data_addr),
      .flag_i     (exec_flag),
      .cause_i    (cause_q),
      .viol_pc_i  (viol_pc_q),
      .cyc_i      (cyc_word),
      .rd_data_o  (rd_data),
      .rd_valid_o (rd_valid)
   );

endmodule

// File: tb/tb_vape_exec_latch.sv
module tb_vape_exec_latch;
   import vape_pkg::*;

   logic        clk;
   logic        reset_n;
   logic [15:0] pc, ER_min, ER_max;
   logic        exec, exec1, exec2, exec3, exec4, exec5;
   logic        data_en, data_wr;
   logic [15:0] data_addr;
   logic        exec_flag;
   logic [15:0] rd_data;
   logic        rd_valid;

   int total = 0;
   int bad   = 0;

   vape_exec_latch dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .pc        (pc),
      .ER_min    (ER_min),
      .ER_max    (ER_max),
      .exec      (exec),
      .exec1     (exec1),
      .exec2     (exec2),
      .exec3     (exec3),
      .exec4     (exec4),
      .exec5     (exec5),
      .data_en   (data_en),
      .data_wr   (data_wr),
      .data_addr (data_addr),
      .exec_flag (exec_flag),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // verd = {exec5..exec1}; exec is the AND of the properties
   task automatic verd(input logic [4:0] v);
      {exec5, exec4, exec3, exec2, exec1} = v;
      exec = &v;
   endtask

   task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
      data_en = 1'b1; data_wr = 1'b0; data_addr = a;
      tick();
      data_en = 1'b0;
      chk({tag, "_vld"}, rd_valid, 1);
      chk(tag, rd_data, exp);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0; pc = 16'h1000; ER_min = 16'hE000; ER_max = 16'hE0FE;
      verd(5'h1F); data_en = 1'b0; data_wr = 1'b0; data_addr = 16'h0;
      tick(); tick();
      chk("rst_flag", exec_flag, 0);
      chk("rst_vld", rd_valid, 0);
      chk("rst_data", rd_data, 0);
      chk("rst_vcnt", dut.vcnt_q, 0);
      chk("rst_state", 32'(dut.state_q), 32'(IDLE));
      reset_n = 1'b1;
      rd(16'hFF0A, 16'h0000, "rst_cause");

      // clean run: entry, 39 in-region steps, exit
      pc = 16'hE000; tick();
      chk("run_flag", exec_flag, 1);
      chk("run_state", 32'(dut.state_q), 32'(RUN));
      for (int i = 1; i <= 39; i++) begin
         pc = 16'hE000 + 16'(2 * i);
         tick();
      end
      pc = 16'hE0FE; tick();
      chk("done_state", 32'(dut.state_q), 32'(DONE));
      chk("done_flag", exec_flag, 1);
      pc = 16'h1000;
      rd(16'hFF08, 16'h0001, "clean_flag");
      rd(16'hFF0A, 16'h0000, "clean_cause");
      rd(16'hFF0E, 16'h0027, "clean_cyc");
      data_en = 1'b1; data_addr = 16'hFF10; tick();
      chk("unmap_vld", rd_valid, 0);
      chk("unmap_hold", rd_data, 16'h0027);
      data_wr = 1'b1; data_addr = 16'hFF08; tick();
      data_en = 1'b0; data_wr = 1'b0;
      chk("wr_vld", rd_valid, 0);
      chk("wr_hold", rd_data, 16'h0027);

      // mid-run violation on the output property
      do_reset();
      pc = 16'hE000; tick();
      for (int i = 1; i <= 7; i++) begin
         pc = 16'hE000 + 16'(2 * i);
         tick();
      end
      pc = 16'hE010; verd(5'b10111); tick();
      chk("mid_flag", exec_flag, 0);
      chk("mid_state", 32'(dut.state_q), 32'(FAIL));
      verd(5'h1F); pc = 16'h1000;
      rd(16'hFF0A, 16'h0008, "mid_cause");
      rd(16'hFF0C, 16'hE010, "mid_pc");
      rd(16'hFF0E, 16'h0007, "mid_cyc");
      chk("mid_vcnt", dut.vcnt_q, 1);
      // second violation while failed keeps first capture
      pc = 16'hE020; verd(5'b11101); tick();
      verd(5'h1F); pc = 16'h1000;
      rd(16'hFF0A, 16'h0008, "keep_cause");
      rd(16'hFF0C, 16'hE010, "keep_pc");
      // re-entry with violation stays failed
      pc = 16'hE000; verd(5'b11110); tick();
      chk("reent_bad_state", 32'(dut.state_q), 32'(FAIL));
      chk("reent_bad_vcnt", dut.vcnt_q, 3);
      verd(5'h1F); pc = 16'h1000;
      rd(16'hFF0A, 16'h0008, "reent_bad_cause");
      // clean re-entry clears records
      pc = 16'hE000; tick();
      chk("reent_flag", exec_flag, 1);
      chk("reent_state", 32'(dut.state_q), 32'(RUN));
      pc = 16'hE002;
      rd(16'hFF0A, 16'h0000, "reent_cause");
      rd(16'hFF0C, 16'h0000, "reent_pc");

      // post-exit tamper; read issued in the same cycle sees the old flag
      do_reset();
      pc = 16'hE000; tick();
      pc = 16'hE0FE; tick();
      chk("pe_done", 32'(dut.state_q), 32'(DONE));
      verd(5'b11110); pc = 16'hE100;
      data_en = 1'b1; data_addr = 16'hFF08; tick();
      data_en = 1'b0;
      chk("pe_rd_vld", rd_valid, 1);
      chk("pe_rd_old", rd_data, 16'h0001);
      chk("pe_flag", exec_flag, 0);
      pc = 16'hE102; tick();
      pc = 16'hE104; tick();
      verd(5'h1F); pc = 16'h1000;
      chk("pe_state", 32'(dut.state_q), 32'(FAIL));
      chk("pe_vcnt", dut.vcnt_q, 3);
      rd(16'hFF0A, 16'h0001, "pe_cause");
      rd(16'hFF0C, 16'hE100, "pe_pc");
      rd(16'hFF0E, 16'h0000, "pe_cyc");

      // configuration change during run
      do_reset();
      pc = 16'hE000; tick();
      pc = 16'hE002; tick();
      pc = 16'hE004; ER_max = 16'hE100; tick();
      chk("cfg_flag", exec_flag, 0);
      chk("cfg_state", 32'(dut.state_q), 32'(FAIL));
      ER_max = 16'hE0FE; pc = 16'h1000;
      rd(16'hFF0A, 16'h0020, "cfg_cause");
      rd(16'hFF0C, 16'hE004, "cfg_pc");
      rd(16'hFF0E, 16'h0001, "cfg_cyc");
      chk("cfg_vcnt", dut.vcnt_q, 0);

      // single-instruction region: straight to DONE
      ER_max = 16'hE000; pc = 16'hE000; tick();
      chk("one_state", 32'(dut.state_q), 32'(DONE));
      chk("one_flag", exec_flag, 1);
      pc = 16'h1000;
      rd(16'hFF0E, 16'h0000, "one_cyc");

      // build up records, then reset in the middle of a run
      pc = 16'h1234; verd(5'b11011); tick();
      verd(5'h1F); pc = 16'h1000;
      rd(16'hFF0A, 16'h0004, "pre_cause");
      ER_max = 16'hE0FE; pc = 16'hE000; tick();
      pc = 16'hE002; tick();
      pc = 16'hE004; tick();
      chk("pre_state", 32'(dut.state_q), 32'(RUN));
      chk("pre_vcnt", dut.vcnt_q, 1);
      reset_n = 1'b0; data_en = 1'b1; data_addr = 16'hFF08; tick();
      reset_n = 1'b1; data_en = 1'b0; pc = 16'h1000;
      chk("mr_flag", exec_flag, 0);
      chk("mr_state", 32'(dut.state_q), 32'(IDLE));
      chk("mr_vld", rd_valid, 0);
      chk("mr_data", rd_data, 0);
      chk("mr_vcnt", dut.vcnt_q, 0);
      chk("mr_cyc", dut.cyc_q, 0);
      rd(16'hFF0A, 16'h0000, "mr_cause");
      rd(16'hFF0C, 16'h0000, "mr_pc");

      // violation counter saturation in IDLE, without capture
      verd(5'b01111);
      for (int i = 0; i < 254; i++) tick();
      chk("sat_254", dut.vcnt_q, 8'hFE);
      tick();
      chk("sat_255", dut.vcnt_q, 8'hFF);
      for (int i = 0; i < 45; i++) tick();
      chk("sat_300", dut.vcnt_q, 8'hFF);
      chk("sat_state", 32'(dut.state_q), 32'(IDLE));
      verd(5'h1F);
      rd(16'hFF0A, 16'h0000, "sat_cause");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
